fifo_stream_reader: RTL
=======================

# fifo_stream_reader

Read-side drain engine for the team's synchronous block-RAM FIFO. It issues read enables against the FIFO's `empty` flag and absorbs the FIFO's one-cycle registered read latency in a two-entry output buffer. Captured words are presented on a valid/ready stream with a `last` marker every `BURST_LEN` words. It sits between the FIFO's read port (`enb`/`doutb`/`empty`) and any downstream consumer such as a DMA packer or serializer.

## Interface
- `DATA_WIDTH`, 16: word width in bits.
- `BURST_LEN`, 256: words per burst; `m_last` marks the final word of each burst; legal range 1..65535.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `enable`  in  1  permits new FIFO reads while high.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_en`  out  1  FIFO read enable (drives FIFO `enb`).
- `fifo_dout`  in  DATA_WIDTH  FIFO registered read data.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accepts.
- `m_data`  out  DATA_WIDTH  output word.
- `m_last`  out  1  final word of the current burst; qualified by `m_valid`.
- `busy`  out  1  a read is in flight or the buffer is non-empty.
- `words_out`  out  32  total words accepted downstream; wraps modulo 2^32.

## Operation
- FIFO contract: a read enable sampled high at edge N yields the word on `fifo_dout` during the cycle after edge N. The reader captures that word at edge N+1.
- `inflight`: 1-bit register, set to the value of `fifo_rd_en` at each edge.
- `count`: buffer occupancy, 0..2. The buffer is a two-entry in-order queue; the head drives `m_data`/`m_valid`.
- `pop` = `m_valid && m_ready`.
- `fifo_rd_en` = `enable && !fifo_empty && (count + inflight - pop) < 2`. This is combinational, includes `m_ready`, and must be glitch-safe relative to `clk` only.
- The reader never asserts `fifo_rd_en` while `fifo_empty` is high, so it never underflows the FIFO.
- Capture: when `inflight` is high, `fifo_dout` is written to the buffer tail at that edge. Push and pop in the same cycle leave `count` unchanged. The buffer never overflows; overflow is an assertion failure.
- Burst counter: 16 bits. It increments on `pop` and clears to 0 on the pop where it equals `BURST_LEN-1`.
- `m_last` = `m_valid && (burst_cnt == BURST_LEN-1)`. With `BURST_LEN=1`, every word is last.
- `words_out` increments by 1 on each `pop`.
- `enable` low: no new reads are issued. The in-flight word and buffered words still drain normally. The burst counter is not cleared.
- `busy` = `inflight || count != 0`.
- Reset mid-operation: the buffer, `inflight`, burst counter and `words_out` are cleared. An in-flight word is discarded; the FIFO is reset alongside on the same `rst`.
- State machine, for debug visibility and internal control:
  - `IDLE`: `count==0` and `!inflight`.
  - `FILL`: `inflight` high and `count==0`.
  - `STREAM`: `count>0`.
  - Transitions follow directly from `count` and `inflight`; there are no other states.

## Timing
- Reset values: `fifo_rd_en=0` (FIFO empty or `enable` low during reset), `m_valid=0`, `m_data=0`, `m_last=0`, `busy=0`, `words_out=0`, burst counter 0.
- Latency: `fifo_empty` falls with `enable` and `m_ready` high in cycle C. `fifo_rd_en` is high in C, data is captured at the end of C+1, and `m_valid` is high in C+2.
- Throughput: with `m_ready` held high and the FIFO non-empty, one word per cycle is sustained indefinitely.
- Backpressure: with `m_ready` low, at most 2 words are buffered. `fifo_rd_en` stays low once `count + inflight == 2`.
- `m_data` and `m_last` hold stable while `m_valid && !m_ready`.
- A simultaneous pop and capture in the same cycle is legal, and `count` is unchanged.

## Test plan
- Single word: write `0x1234` to FIFO, `enable=1`, `m_ready=1` -> one `fifo_rd_en` pulse; `m_valid` high 2 cycles later with `m_data=0x1234`; `words_out=1`; `busy` returns to 0.
- Streaming: 100 words 0..99 preloaded, `m_ready=1` -> 100 consecutive `m_valid` cycles in order with no gaps; `words_out=100`.
- Backpressure: 10 words preloaded, `m_ready=0` for 20 cycles -> exactly 2 `fifo_rd_en` pulses, `m_data=0` held. On release, words 0..9 arrive in order with none lost or duplicated.
- Bursts: `BURST_LEN=4`, 10 words -> `m_last` on words 3 and 7 only; the burst counter reads 2 after completion.
- Enable gating: deassert `enable` one cycle after the first `fifo_rd_en` with 8 words queued -> only words already in flight or buffered are delivered. Re-enabling resumes with the next word in order.
- Reset mid-stream: assert `rst` while `count=2` and `inflight=1` -> next cycle `m_valid=0`, `busy=0`, `words_out=0`. After release and refill, output restarts cleanly with `m_last` counting from 0.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Read-side drain engine for the synchronous block-RAM FIFO: issues reads against
// `empty`, absorbs the one-cycle read latency in a two-entry buffer, streams out with `last`.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic [31:0]           words_out,
    output logic [1:0]            state_dbg
);

    // Stream handshake: a word transfers on every rising edge where m_valid && m_ready;
    // m_data/m_last are held stable while m_valid is high and m_ready is low.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } state_t;

    localparam logic [15:0] LAST_IDX = 16'(BURST_LEN - 1);

    state_t                  state;
    state_t                  state_next;
    logic [1:0]              count;
    logic [1:0]              count_next;
    logic                    inflight;
    logic [DATA_WIDTH-1:0]   buf0;
    logic [DATA_WIDTH-1:0]   buf1;
    logic [15:0]             burst_cnt;
    logic                    pop;
    logic                    push;
    logic [2:0]              occ_after_pop;

    assign pop  = m_valid && m_ready;
    assign push = inflight;

    // Occupancy this cycle would leave behind once the current pop completes.
    assign occ_after_pop = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_rd_en    = enable && !fifo_empty && (occ_after_pop < 3'd2);
    assign count_next    = occ_after_pop[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (count_next != 2'd0) begin
            state_next = STREAM;
        end else if (fifo_rd_en) begin
            state_next = FILL;
        end else begin
            state_next = IDLE;
        end
    end

    assign m_valid   = (state == STREAM);
    assign busy      = (state != IDLE);
    assign m_data    = buf0;
    assign m_last    = m_valid && (burst_cnt == LAST_IDX);
    assign state_dbg = state;

    // buf0 is the head; the tail is buf0 when empty (or emptying) and buf1 otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf0     <= '0;
            buf1     <= '0;
            count    <= 2'd0;
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            count    <= count_next;
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) buf0 <= fifo_dout;
                    else               buf1 <= fifo_dout;
                end
                2'b01: buf0 <= buf1;
                2'b11: begin
                    if (count == 2'd1) begin
                        buf0 <= fifo_dout;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= fifo_dout;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt <= 16'd0;
            words_out <= 32'd0;
        end else if (pop) begin
            burst_cnt <= (burst_cnt == LAST_IDX) ? 16'd0 : burst_cnt + 16'd1;
            words_out <= words_out + 32'd1;
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && count == 2'd2));
    a_no_underflow : assert property (@(posedge clk) disable iff (rst)
        !(fifo_rd_en && fifo_empty));

endmodule
